// File: rtl/stopwatch_pkg.sv
// rtl/stopwatch_pkg.sv - shared types and limits for the centisecond stopwatch
package stopwatch_pkg;

    localparam int CNT_W = 16;
    localparam logic [CNT_W-1:0] MAX_CS = 16'd59999;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_RUNNING = 2'd1,
        ST_PAUSED  = 2'd2
    } sw_state_e;

endpackage

// File: rtl/stopwatch_counter_tick_gen.sv
// rtl/stopwatch_counter_tick_gen.sv - prescaler emitting one tick every DIV enabled cycles
module tick_gen #(
    parameter int DIV = 4
) (
    input  logic clk,
    input  logic rst_n,
    input  logic en,
    input  logic clr,
    output logic tick
);

    localparam int PW = (DIV > 2) ? $clog2(DIV) : 1;
    localparam logic [PW-1:0] LAST = PW'(DIV - 1);

    logic [PW-1:0] pre_q;
    logic [PW-1:0] pre_d;

    // clr wins over en so the phase restarts cleanly from zero
    always_comb begin
        tick  = en && (pre_q == LAST);
        pre_d = pre_q;
        if (clr) begin
            pre_d = '0;
        end else if (en) begin
            pre_d = tick ? '0 : pre_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pre_q <= '0;
        end else begin
            pre_q <= pre_d;
        end
    end

endmodule

// File: rtl/stopwatch_counter.sv
// rtl/stopwatch_counter.sv - run/pause/clear stopwatch counting centiseconds 0..59999
// Optional lap display hold is built when STOPWATCH_LAP_EN is defined.
module stopwatch_counter
    import stopwatch_pkg::*;
#(
    parameter int CLK_FREQ_HZ = 100_000_000,
    parameter int TICK_HZ     = 100
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start_stop,
    input  logic             clear,
`ifdef STOPWATCH_LAP_EN
    input  logic             lap,
`endif
    output logic [CNT_W-1:0] bin,
    output logic             running,
    output logic             wrap
);

    localparam int DIV = CLK_FREQ_HZ / TICK_HZ;

    generate
        if (DIV < 2) begin : g_div_check
            $error("stopwatch_counter: CLK_FREQ_HZ/TICK_HZ must be at least 2");
        end
    endgenerate

    sw_state_e        state_q, state_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic [CNT_W-1:0] bin_q, bin_d;
    logic             running_q, running_d;
    logic             wrap_q, wrap_d;
    logic             tick;

    tick_gen #(
        .DIV (DIV)
    ) u_tick_gen (
        .clk   (clk),
        .rst_n (rst_n),
        .en    (state_q == ST_RUNNING),
        .clr   (clear || (state_q == ST_IDLE)),
        .tick  (tick)
    );

`ifdef STOPWATCH_LAP_EN
    logic hold_q, hold_d;

    always_comb begin
        hold_d = hold_q;
        if (clear) begin
            hold_d = 1'b0;
        end else if (lap && (state_q != ST_IDLE)) begin
            hold_d = ~hold_q;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hold_q <= 1'b0;
        end else begin
            hold_q <= hold_d;
        end
    end
`endif

    // A tick coinciding with start_stop still counts; clear overrides both
    always_comb begin
        state_d = state_q;
        count_d = count_q;
        wrap_d  = 1'b0;
        if (clear) begin
            state_d = ST_IDLE;
            count_d = '0;
        end else begin
            if (tick) begin
                count_d = (count_q == MAX_CS) ? '0 : count_q + 16'd1;
                wrap_d  = (count_q == MAX_CS);
            end
            if (start_stop) begin
                case (state_q)
                    ST_IDLE:    state_d = ST_RUNNING;
                    ST_RUNNING: state_d = ST_PAUSED;
                    ST_PAUSED:  state_d = ST_RUNNING;
                    default:    state_d = ST_IDLE;
                endcase
            end
        end
        running_d = (state_d == ST_RUNNING);
`ifdef STOPWATCH_LAP_EN
        bin_d = hold_d ? bin_q : count_d;
`else
        bin_d = count_d;
`endif
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= ST_IDLE;
            count_q   <= '0;
            bin_q     <= '0;
            running_q <= 1'b0;
            wrap_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            count_q   <= count_d;
            bin_q     <= bin_d;
            running_q <= running_d;
            wrap_q    <= wrap_d;
        end
    end

    assign bin     = bin_q;
    assign running = running_q;
    assign wrap    = wrap_q;

endmodule
